// File: rtl/dadda_mul_pipe_if.sv
// Valid/ready stream bundle for the pipelined Dadda multiplier.
// master = operand source / result consumer, slave = the multiplier.
interface dadda_mul_pipe_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_GUARD = 4
);
    logic                           in_valid;
    logic                           in_ready;
    logic [WIDTH-1:0]               in_a;
    logic [WIDTH-1:0]               in_b;
    logic                           in_signed;
    logic                           in_acc;
    logic                           out_valid;
    logic                           out_ready;
    logic [2*WIDTH+ACC_GUARD-1:0]   out_prod;

    modport master (
        output in_valid, in_a, in_b, in_signed, in_acc, out_ready,
        input  in_ready, out_valid, out_prod
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, in_acc, out_ready,
        output in_ready, out_valid, out_prod
    );
endinterface

// File: rtl/dadda_mul_pipe.sv
// Three-stage WIDTHxWIDTH Dadda-tree multiplier (unsigned or Baugh-Wooley signed per transaction).
// Optional accumulator in the last stage is enabled by defining DADDA_MUL_ACC_EN.
module dadda_mul_pipe #(
    parameter int WIDTH     = 8,
    parameter int ACC_GUARD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    dadda_mul_pipe_if.slave bus
);
    localparam int NCOL  = 2 * WIDTH;
    localparam int MAXH  = WIDTH + 2;
    localparam int OW    = NCOL + ACC_GUARD;
    localparam int NUM_D = 8;

    // Dadda height targets, largest first; stages whose target exceeds the matrix height are no-ops.
    function automatic int dadda_target(input int s);
        int d;
        case (s)
            0:       d = 28;
            1:       d = 19;
            2:       d = 13;
            3:       d = 9;
            4:       d = 6;
            5:       d = 4;
            6:       d = 3;
            default: d = 2;
        endcase
        return d;
    endfunction

    // Bits per column of the initial matrix; the two signed correction bits sit in columns WIDTH and 2*WIDTH-1.
    function automatic int col_height(input int c);
        int h;
        if (c >= NCOL - 1) begin
            h = 1;
        end else begin
            h = (c < WIDTH) ? c + 1 : NCOL - 1 - c;
            if (c == WIDTH) h = h + 1;
        end
        return h;
    endfunction

    function automatic logic [2*NCOL-1:0] reduce_matrix(input logic [NCOL-1:0][MAXH-1:0] m);
        logic [NCOL-1:0][MAXH-1:0] cur;
        logic [NCOL-1:0][MAXH-1:0] nxt;
        int                        cnt  [NCOL];
        int                        ncnt [NCOL];
        int                        eff;
        int                        p;
        int                        d;
        logic                      carry;
        logic [NCOL-1:0]           r0;
        logic [NCOL-1:0]           r1;
        cur = m;
        for (int c = 0; c < NCOL; c++) cnt[c] = col_height(c);
        for (int s = 0; s < NUM_D; s++) begin
            d   = dadda_target(s);
            nxt = '0;
            for (int c = 0; c < NCOL; c++) ncnt[c] = 0;
            for (int c = 0; c < NCOL; c++) begin
                p   = 0;
                eff = cnt[c] + ncnt[c];
                // Carries already pushed in from column c-1 count towards this column's height.
                for (int t = 0; t < MAXH; t++) begin
                    if (eff > d && cnt[c] - p >= 2) begin
                        if (eff > d + 1 && cnt[c] - p >= 3) begin
                            nxt[c][ncnt[c]] = cur[c][p] ^ cur[c][p+1] ^ cur[c][p+2];
                            carry = (cur[c][p] & cur[c][p+1]) | (cur[c][p] & cur[c][p+2]) |
                                    (cur[c][p+1] & cur[c][p+2]);
                            p   = p + 3;
                            eff = eff - 2;
                        end else begin
                            nxt[c][ncnt[c]] = cur[c][p] ^ cur[c][p+1];
                            carry = cur[c][p] & cur[c][p+1];
                            p   = p + 2;
                            eff = eff - 1;
                        end
                        ncnt[c] = ncnt[c] + 1;
                        if (c + 1 < NCOL) begin
                            nxt[c+1][ncnt[c+1]] = carry;
                            ncnt[c+1] = ncnt[c+1] + 1;
                        end
                    end
                end
                for (int t = 0; t < MAXH; t++) begin
                    if (p < cnt[c]) begin
                        nxt[c][ncnt[c]] = cur[c][p];
                        ncnt[c] = ncnt[c] + 1;
                        p = p + 1;
                    end
                end
            end
            cur = nxt;
            cnt = ncnt;
        end
        for (int c = 0; c < NCOL; c++) begin
            r0[c] = cur[c][0];
            r1[c] = cur[c][1];
        end
        return {r1, r0};
    endfunction

    logic                      s1_v, s2_v, s3_v;
    logic                      s1_sgn, s2_sgn;
    logic [NCOL-1:0][MAXH-1:0] s1_pp;
    logic [NCOL-1:0][MAXH-1:0] pp_next;
    logic [NCOL-1:0]           s2_row0, s2_row1;
    logic [2*NCOL-1:0]         rows_next;
    logic [NCOL-1:0]           sum_s3;
    logic [OW-1:0]             ext_s3;
    logic [OW-1:0]             result_next;
    logic [OW-1:0]             prod_q;
    logic                      en1, en2, en3;

    assign en3 = ~s3_v | bus.out_ready;
    assign en2 = ~s2_v | en3;
    assign en1 = ~s1_v | en2;

    assign bus.in_ready  = en1;
    assign bus.out_valid = s3_v;
    assign bus.out_prod  = prod_q;

    // Baugh-Wooley: invert terms with exactly one MSB operand, add 2^WIDTH + 2^(2*WIDTH-1) when signed.
    always_comb begin
        pp_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp_next[i+j][(i + j < WIDTH) ? i : WIDTH - 1 - j] =
                    (bus.in_a[j] & bus.in_b[i]) ^
                    (bus.in_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
        pp_next[WIDTH][WIDTH-1] = bus.in_signed;
        pp_next[NCOL-1][0]      = bus.in_signed;
    end

    always_comb begin
        rows_next = reduce_matrix(s1_pp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_sgn <= 1'b0;
            s1_pp  <= '0;
        end else if (en1) begin
            s1_v   <= bus.in_valid;
            s1_sgn <= bus.in_signed;
            s1_pp  <= pp_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_sgn  <= 1'b0;
            s2_row0 <= '0;
            s2_row1 <= '0;
        end else if (en2) begin
            s2_v    <= s1_v;
            s2_sgn  <= s1_sgn;
            s2_row0 <= rows_next[NCOL-1:0];
            s2_row1 <= rows_next[2*NCOL-1:NCOL];
        end
    end

    // Final carry-propagate add wraps modulo 2^(2*WIDTH), which the Baugh-Wooley constants rely on.
    assign sum_s3 = s2_row0 + s2_row1;
    assign ext_s3 = {{ACC_GUARD{s2_sgn & sum_s3[NCOL-1]}}, sum_s3};

`ifdef DADDA_MUL_ACC_EN
    logic          s1_acc, s2_acc;
    logic [OW-1:0] acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_acc <= 1'b0;
            s2_acc <= 1'b0;
        end else begin
            if (en1) s1_acc <= bus.in_acc;
            if (en2) s2_acc <= s1_acc;
        end
    end

    assign result_next = s2_acc ? acc_q + ext_s3 : ext_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en3 && s2_v) begin
            acc_q <= result_next;
        end
    end
`else
    assign result_next = ext_s3;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_v   <= 1'b0;
            prod_q <= '0;
        end else if (en3) begin
            s3_v <= s2_v;
            if (s2_v) prod_q <= result_next;
        end
    end
endmodule

// File: tb/tb_dadda_mul_pipe.sv
// Self-checking bench for dadda_mul_pipe: arithmetic reference model plus literal corner cases.
// Accumulator scenarios run only when DADDA_MUL_ACC_EN is defined.
module tb_dadda_mul_pipe;
    localparam int W  = 8;
    localparam int G  = 4;
    localparam int OW = 2 * W + G;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dadda_mul_pipe_if #(.WIDTH(W), .ACC_GUARD(G)) bus ();
    dadda_mul_pipe #(.WIDTH(W), .ACC_GUARD(G)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int            checks = 0;
    int            errors = 0;
    logic [OW-1:0] exp_q [$];
    logic [OW-1:0] acc_m     = '0;
    logic [OW-1:0] last_prod = '0;
    logic [OW-1:0] held      = '0;
    logic          stall_prev = 1'b0;
    logic          saw_full   = 1'b0;

    task automatic checkOutput(input string name, input logic [OW-1:0] actual, input logic [OW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Product from plain integer arithmetic, truncated to the output width (gives sign/zero extension).
    function automatic logic [OW-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        int pa;
        int pb;
        if (sgn) begin
            pa = int'($signed(a));
            pb = int'($signed(b));
        end else begin
            pa = int'(a);
            pb = int'(b);
        end
        return OW'(pa * pb);
    endfunction

    // Sampling on the falling edge sees the handshakes that will complete at the next rising edge.
    always @(negedge clk) begin
        logic [OW-1:0] p;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            checkOutput("in_ready", OW'(bus.in_ready), OW'((exp_q.size() < 3) || bus.out_ready));
            if (!bus.in_ready) saw_full = 1'b1;
            if (stall_prev) begin
                checkOutput("stall_valid", OW'(bus.out_valid), OW'(1));
                checkOutput("stall_prod", bus.out_prod, held);
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_out", OW'(1), OW'(0));
                end else begin
                    checkOutput("stream_prod", bus.out_prod, exp_q[0]);
                    if (bus.out_ready) begin
                        last_prod = bus.out_prod;
                        void'(exp_q.pop_front());
                    end
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held       = bus.out_prod;
            if (bus.in_valid && bus.in_ready) begin
                p = model_prod(bus.in_a, bus.in_b, bus.in_signed);
`ifdef DADDA_MUL_ACC_EN
                acc_m = bus.in_acc ? acc_m + p : p;
                exp_q.push_back(acc_m);
`else
                exp_q.push_back(p);
`endif
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, input logic acc);
        logic hs;
        int   n;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_signed = sgn;
        bus.in_acc    = acc;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) checkOutput("accept_timeout", OW'(0), OW'(1));
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) checkOutput("drain_timeout", OW'(exp_q.size()), OW'(0));
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        exp_q.delete();
        acc_m = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cycles;
        logic [W-1:0]  ca [3];
        logic [W-1:0]  cb [3];
        logic [OW-1:0] ce [3];
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_signed = 1'b0;
        bus.in_acc    = 1'b0;
        bus.out_ready = 1'b1;
        doReset();
        checkOutput("rst_out_valid", OW'(bus.out_valid), OW'(0));
        checkOutput("rst_out_prod", bus.out_prod, OW'(0));
        checkOutput("rst_in_ready", OW'(bus.in_ready), OW'(1));

        // Unsigned 255*255 with latency measured from the accepting edge.
        applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0);
        cycles = 1;
        while (!bus.out_valid && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("latency", OW'(cycles), OW'(3));
        checkOutput("u255x255", bus.out_prod, 20'h0FE01);
        waitDrain();

        ca = '{8'h80, 8'hFF, 8'h80};
        cb = '{8'h80, 8'h01, 8'h7F};
        ce = '{20'h04000, 20'hFFFFF, 20'hFC080};
        for (int k = 0; k < 3; k++) begin
            applyStimulus(ca[k], cb[k], 1'b1, 1'b0);
            waitDrain();
            checkOutput($sformatf("signed_corner%0d", k), last_prod, ce[k]);
        end

        // Random mixed-mode stream with a 5-cycle consumer stall in the middle.
        saw_full = 1'b0;
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("inready_drop", OW'(saw_full), OW'(1));

        // Fill all three stages, then reset mid-flight.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus(W'(k + 1), 8'h11, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_valid", OW'(bus.out_valid), OW'(0));
        exp_q.delete();
        acc_m = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        applyStimulus(8'd3, 8'd4, 1'b0, 1'b0);
        waitDrain();
        checkOutput("post_rst_3x4", last_prod, OW'(12));

`ifdef DADDA_MUL_ACC_EN
        doReset();
        applyStimulus(8'd3, 8'd4, 1'b0, 1'b0);
        waitDrain();
        checkOutput("acc_first", last_prod, OW'(12));
        applyStimulus(8'd5, 8'd6, 1'b0, 1'b1);
        waitDrain();
        checkOutput("acc_add", last_prod, OW'(42));
        applyStimulus(8'd2, 8'd2, 1'b0, 1'b0);
        waitDrain();
        checkOutput("acc_restart", last_prod, OW'(4));

        // 17 * 65025 = 1105425, which is 0x0DE11 modulo 2^20.
        doReset();
        for (int k = 0; k < 17; k++) applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b1);
        waitDrain();
        checkOutput("acc_wrap", last_prod, 20'h0DE11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time expired, required completion before 500000");
        $fatal(1, "[TB] watchdog");
    end
endmodule
